windowed_reg_file: RTL and testbench

- Parametrised register file with sliding, overlapping register windows, for the next-generation datapath.
- Window shift (call/return) is driven by the ALU control unit's window-control and window-load strobes.
- When the physical file runs out of windows, a spill/fill engine saves or restores the oldest window's private registers to backing memory over a req/ack handshake.
- While the engine runs, the core is stalled through busy.

---
 rtl/windowed_reg_file.sv | 193 +++++++++++++++++++
 tb/tb_windowed_reg_file.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_reg_file.sv
// Windowed register file: overlapping windows over a circular physical file, with a spill/fill engine.
// Reads combinational; writes/shifts at the edge; busy holds while STEP memAck-paced transfers run.
module windowed_reg_file #(
    parameter int DATA_W     = 8,
    parameter int NWIN       = 4,
    parameter int REGS       = 8,
    parameter int STEP       = 4,
    parameter int SPILL_WNDS = 16,
    localparam int RA_W      = $clog2(REGS),
    localparam int CW        = $clog2(NWIN),
    localparam int MEM_AW    = $clog2(SPILL_WNDS * STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   rdAddr1,
    input  logic [RA_W-1:0]   rdAddr2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2,
    input  logic              regWrite,
    input  logic [RA_W-1:0]   wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              ldWnd,
    input  logic [1:0]        wndCtrl,
    output logic              busy,
    output logic [CW-1:0]     cwp,
    output logic              wndErr,
    output logic              memReq,
    output logic              memWe,
    output logic [MEM_AW-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck
);
    localparam int PHYS = NWIN * STEP;
    localparam int PA_W = $clog2(PHYS);
    localparam int KW   = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int DP_W = $clog2(SPILL_WNDS + 1);
    localparam logic [CW-1:0]   RES_FULL   = CW'(NWIN - 1);
    localparam logic [CW-1:0]   RES_ONE    = CW'(1);
    localparam logic [DP_W-1:0] DEPTH_FULL = DP_W'(SPILL_WNDS);
    localparam logic [KW-1:0]   K_LAST     = KW'(STEP - 1);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   phys [PHYS];
    logic [CW-1:0]       oldest;
    logic [CW-1:0]       res;
    logic [MEM_AW-1:0]   sp;
    logic [DP_W-1:0]     depth;
    logic [KW-1:0]       k;

    logic                do_call;
    logic                do_ret;
    logic                last_ack;
    logic [CW-1:0]       cwp_dec;
    logic [PA_W-1:0]     wr_idx;
    logic [PA_W-1:0]     spill_idx;
    logic [PA_W-1:0]     fill_idx;

    // Physical slot of logical register r in window w; PHYS need not be a power of two.
    function automatic logic [PA_W-1:0] phys_idx(input int w, input int r);
        int t;
        t = (w * STEP + r) % PHYS;
        return PA_W'(t);
    endfunction

    assign do_call   = ldWnd && (wndCtrl == 2'b01);
    assign do_ret    = ldWnd && (wndCtrl == 2'b10);
    assign last_ack  = memAck && (k == K_LAST);
    assign cwp_dec   = cwp - CW'(1);
    assign wr_idx    = phys_idx(int'(cwp), int'(wrAddr));
    assign spill_idx = phys_idx(int'(oldest), int'(k));
    // Fill restores the window below cwp from its top register downwards, mirroring the spill order.
    assign fill_idx  = phys_idx(int'(cwp_dec), STEP - 1 - int'(k));
    assign rdData1   = phys[phys_idx(int'(cwp), int'(rdAddr1))];
    assign rdData2   = phys[phys_idx(int'(cwp), int'(rdAddr2))];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (do_call && (res == RES_FULL) && (depth != DEPTH_FULL)) begin
                    state_next = SPILL;
                end else if (do_ret && (res == RES_ONE) && (depth != '0)) begin
                    state_next = FILL;
                end
            end
            SPILL, FILL: begin
                if (last_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        unique case (state)
            SPILL: begin
                busy     = 1'b1;
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = sp;
                memWData = phys[spill_idx];
            end
            FILL: begin
                busy    = 1'b1;
                memReq  = 1'b1;
                memAddr = sp - MEM_AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHYS; i++) begin
                phys[i] <= '0;
            end
            cwp    <= '0;
            oldest <= '0;
            res    <= RES_ONE;
            sp     <= '0;
            depth  <= '0;
            k      <= '0;
            wndErr <= 1'b0;
        end else begin
            wndErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    k <= '0;
                    if (regWrite) begin
                        phys[wr_idx] <= wrData;
                    end
                    if (do_call) begin
                        if (res != RES_FULL) begin
                            cwp <= cwp + CW'(1);
                            res <= res + CW'(1);
                        end else if (depth == DEPTH_FULL) begin
                            wndErr <= 1'b1;
                        end
                    end else if (do_ret) begin
                        if (res != RES_ONE) begin
                            cwp <= cwp_dec;
                            res <= res - CW'(1);
                        end else if (depth == '0) begin
                            wndErr <= 1'b1;
                        end
                    end
                end
                SPILL: begin
                    if (memAck) begin
                        sp <= sp + MEM_AW'(1);
                        k  <= k + KW'(1);
                        if (last_ack) begin
                            oldest <= oldest + CW'(1);
                            depth  <= depth + DP_W'(1);
                            cwp    <= cwp + CW'(1);
                        end
                    end
                end
                FILL: begin
                    if (memAck) begin
                        phys[fill_idx] <= memRData;
                        sp <= sp - MEM_AW'(1);
                        k  <= k + KW'(1);
                        if (last_ack) begin
                            oldest <= oldest - CW'(1);
                            depth  <= depth - DP_W'(1);
                            cwp    <= cwp_dec;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_windowed_reg_file.sv
// Bench for windowed_reg_file: directed plan steps followed by random traffic, all checked against
// a transfer-level reference model and a small backing memory with configurable ack delay.
module tb_windowed_reg_file;
    localparam int NWIN = 4;
    localparam int STEP = 4;
    localparam int SPILL_WNDS = 16;
    localparam int PHYS = NWIN * STEP;
    localparam int MEMW = SPILL_WNDS * STEP;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rdAddr1, rdAddr2, wrAddr;
    logic [7:0] rdData1, rdData2, wrData, memWData, memRData;
    logic       regWrite, ldWnd, busy, wndErr, memReq, memWe, memAck;
    logic [1:0] wndCtrl, cwp;
    logic [5:0] memAddr;

    always #5 clk = ~clk;

    windowed_reg_file #(.DATA_W(8), .NWIN(NWIN), .REGS(8), .STEP(STEP), .SPILL_WNDS(SPILL_WNDS)) dut (
        .clk(clk), .rst(rst), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
        .regWrite(regWrite), .wrAddr(wrAddr), .wrData(wrData), .ldWnd(ldWnd), .wndCtrl(wndCtrl),
        .busy(busy), .cwp(cwp), .wndErr(wndErr), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData), .memAck(memAck)
    );

    // Backing memory: acks after ack_delay waiting cycles of a held request.
    logic [7:0] bmem [MEMW];
    int wcnt = 0;
    int ack_delay = 0;
    int log_addr[$], log_data[$], log_we[$];

    assign memAck   = memReq && (wcnt >= ack_delay);
    assign memRData = bmem[memAddr];

    always @(posedge clk) begin
        if (memReq && memAck) begin
            if (memWe) bmem[memAddr] <= memWData;
            log_addr.push_back(int'(memAddr));
            log_data.push_back(int'(memWe ? memWData : memRData));
            log_we.push_back(int'(memWe));
        end
        if (!memReq || memAck) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // Reference model: window bookkeeping by plain arithmetic, spill/fill as a queue of transfers.
    logic [7:0] m_phys [PHYS];
    logic [7:0] m_mem [MEMW];
    int m_cwp, m_oldest, m_res, m_depth, m_mode;
    bit m_err;
    int q_addr[$], q_idx[$];
    int total = 0, bad = 0;

    function automatic int pidx(input int w, input int r);
        int wm;
        wm = ((w % NWIN) + NWIN) % NWIN;
        return (wm * STEP + r) % PHYS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < PHYS; i++) m_phys[i] = 8'h00;
        m_cwp = 0; m_oldest = 0; m_res = 1; m_depth = 0; m_mode = 0; m_err = 1'b0;
        q_addr.delete(); q_idx.delete();
    endtask

    task automatic check_outputs();
        chk("cwp", 32'(cwp), 32'(m_cwp));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("wndErr", 32'(wndErr), 32'(m_err));
        chk("memReq", 32'(memReq), 32'(m_mode != 0));
        chk("rdData1", 32'(rdData1), 32'(m_phys[pidx(m_cwp, int'(rdAddr1))]));
        chk("rdData2", 32'(rdData2), 32'(m_phys[pidx(m_cwp, int'(rdAddr2))]));
        if (m_mode == 1) begin
            chk("spill_we", 32'(memWe), 32'(1));
            chk("spill_addr", 32'(memAddr), 32'(q_addr[0]));
            chk("spill_data", 32'(memWData), 32'(m_phys[q_idx[0]]));
        end else if (m_mode == 2) begin
            chk("fill_we", 32'(memWe), 32'(0));
            chk("fill_addr", 32'(memAddr), 32'(q_addr[0]));
        end
    endtask

    task automatic model_edge();
        bit ack;
        ack = (m_mode != 0) && memAck;
        m_err = 1'b0;
        if (rst) begin
            reset_model();
        end else if (m_mode == 0) begin
            if (regWrite) m_phys[pidx(m_cwp, int'(wrAddr))] = wrData;
            if (ldWnd && wndCtrl == 2'b01) begin
                if (m_res < NWIN - 1) begin
                    m_cwp = (m_cwp + 1) % NWIN; m_res++;
                end else if (m_depth < SPILL_WNDS) begin
                    m_mode = 1;
                    for (int j = 0; j < STEP; j++) begin
                        q_addr.push_back((m_depth * STEP + j) % MEMW);
                        q_idx.push_back(pidx(m_oldest, j));
                    end
                end else m_err = 1'b1;
            end else if (ldWnd && wndCtrl == 2'b10) begin
                if (m_res > 1) begin
                    m_cwp = (m_cwp + NWIN - 1) % NWIN; m_res--;
                end else if (m_depth > 0) begin
                    m_mode = 2;
                    for (int j = 0; j < STEP; j++) begin
                        q_addr.push_back((m_depth * STEP - 1 - j + MEMW) % MEMW);
                        q_idx.push_back(pidx(m_cwp - 1, STEP - 1 - j));
                    end
                end else m_err = 1'b1;
            end
        end else if (ack) begin
            if (m_mode == 1) m_mem[q_addr[0]] = m_phys[q_idx[0]];
            else m_phys[q_idx[0]] = m_mem[q_addr[0]];
            void'(q_addr.pop_front());
            void'(q_idx.pop_front());
            if (q_addr.size() == 0) begin
                if (m_mode == 1) begin
                    m_oldest = (m_oldest + 1) % NWIN; m_depth++; m_cwp = (m_cwp + 1) % NWIN;
                end else begin
                    m_oldest = (m_oldest + NWIN - 1) % NWIN; m_depth--; m_cwp = (m_cwp + NWIN - 1) % NWIN;
                end
                m_mode = 0;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        regWrite = 1'b1; wrAddr = 3'(a); wrData = 8'(d);
        rdAddr1 = 3'($urandom); rdAddr2 = 3'($urandom);
        tick();
        regWrite = 1'b0;
    endtask

    task automatic wnd(input int c);
        ldWnd = 1'b1; wndCtrl = 2'(c);
        rdAddr1 = 3'($urandom); rdAddr2 = 3'($urandom);
        tick();
        ldWnd = 1'b0; wndCtrl = 2'b00;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (m_mode != 0 && n < limit) begin
            rdAddr1 = 3'($urandom); rdAddr2 = 3'($urandom);
            tick();
            n++;
        end
        chk("idle_timeout", 32'(m_mode == 0), 32'(1));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < MEMW; i++) begin bmem[i] = 8'h00; m_mem[i] = 8'h00; end
        rst = 1'b1; regWrite = 1'b0; ldWnd = 1'b0; wndCtrl = 2'b00;
        wrAddr = 3'd0; wrData = 8'h00; rdAddr1 = 3'd0; rdAddr2 = 3'd0;
        reset_model();
        @(negedge clk);
        repeat (2) begin #1; model_edge(); @(posedge clk); @(negedge clk); end
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_cwp", 32'(cwp), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_memReq", 32'(memReq), 32'(0));
        chk("rst_wndErr", 32'(wndErr), 32'(0));
        for (int r = 0; r < 8; r++) begin
            rdAddr1 = 3'(r); rdAddr2 = 3'(7 - r);
            #1 chk("rst_reg", 32'(rdData1), 32'(0));
            tick();
        end

        // Overlap between window 0 and window 1
        wr(4, 'hA5);
        wnd(1);
        rdAddr1 = 3'd0; rdAddr2 = 3'd4;
        #1;
        chk("ovl_cwp", 32'(cwp), 32'(1));
        chk("ovl_r0", 32'(rdData1), 32'hA5);
        chk("ovl_r4", 32'(rdData2), 32'h00);
        tick();
        wnd(2);

        // Spill on the third call
        for (int r = 0; r < 4; r++) wr(r, 'h10 + r);
        ack_delay = 2;
        wnd(1);
        wnd(1);
        log_addr.delete(); log_data.delete(); log_we.delete();
        wnd(1);
        #1 chk("spill_busy", 32'(busy), 32'(1));
        wait_idle(100, n);
        chk("spill_cycles", 32'(n), 32'(STEP * 3));
        chk("spill_count", 32'(log_addr.size()), 32'(4));
        for (int j = 0; j < 4 && j < log_addr.size(); j++) begin
            chk("spill_log_addr", 32'(log_addr[j]), 32'(j));
            chk("spill_log_data", 32'(log_data[j]), 32'(8'h10 + j));
            chk("spill_log_we", 32'(log_we[j]), 32'(1));
        end
        #1 chk("spill_cwp", 32'(cwp), 32'(3));
        // Window 3's upper half aliases the spilled slots; clobber them so the fill must restore them.
        for (int r = 4; r < 8; r++) wr(r, 'hE0 + r);

        // Fill on the third return
        wnd(2);
        wnd(2);
        log_addr.delete(); log_data.delete(); log_we.delete();
        wnd(2);
        wait_idle(100, n);
        chk("fill_count", 32'(log_addr.size()), 32'(4));
        for (int j = 0; j < 4 && j < log_addr.size(); j++) begin
            chk("fill_log_addr", 32'(log_addr[j]), 32'(3 - j));
            chk("fill_log_we", 32'(log_we[j]), 32'(0));
        end
        #1 chk("fill_cwp", 32'(cwp), 32'(0));
        for (int r = 0; r < 4; r++) begin
            rdAddr1 = 3'(r);
            #1 chk("fill_reg", 32'(rdData1), 32'(8'h10 + r));
            tick();
        end

        // Underflow right after reset
        pulse_reset();
        wnd(2);
        #1;
        chk("uf_err", 32'(wndErr), 32'(1));
        chk("uf_cwp", 32'(cwp), 32'(0));
        chk("uf_busy", 32'(busy), 32'(0));
        tick();
        #1 chk("uf_err_drop", 32'(wndErr), 32'(0));

        // Writes and window strobes ignored while busy; reset aborts a spill
        pulse_reset();
        ack_delay = 1;
        wnd(1);
        wnd(1);
        log_addr.delete(); log_data.delete(); log_we.delete();
        wnd(1);
        regWrite = 1'b1; wrAddr = 3'd0; wrData = 8'hFF;
        ldWnd = 1'b1; wndCtrl = 2'b10; rdAddr1 = 3'd0; rdAddr2 = 3'd1;
        n = 0;
        while (log_addr.size() < 2 && n < 20) begin tick(); n++; end
        chk("busy_ack_timeout", 32'(log_addr.size()), 32'(2));
        #1;
        chk("busy_wr_ignored", 32'(rdData1), 32'(0));
        chk("busy_ld_ignored", 32'(cwp), 32'(2));
        regWrite = 1'b0; ldWnd = 1'b0; wndCtrl = 2'b00;
        pulse_reset();
        #1;
        chk("abort_memReq", 32'(memReq), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_cwp", 32'(cwp), 32'(0));
        tick();

        // Fill backing memory to capacity, overflow, then unwind to underflow
        ack_delay = 0;
        for (int i = 0; i < 2 + SPILL_WNDS; i++) begin
            wr($urandom_range(0, 7), $urandom_range(0, 255));
            wnd(1);
            wait_idle(50, n);
        end
        wnd(1);
        #1;
        chk("ovf_err", 32'(wndErr), 32'(1));
        chk("ovf_busy", 32'(busy), 32'(0));
        chk("ovf_cwp", 32'(cwp), 32'(2));
        for (int i = 0; i < 2 + SPILL_WNDS; i++) begin
            wnd(2);
            wait_idle(50, n);
        end
        wnd(2);
        #1;
        chk("deep_uf_err", 32'(wndErr), 32'(1));
        chk("deep_uf_cwp", 32'(cwp), 32'(0));

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if (m_mode == 0) ack_delay = $urandom_range(0, 3);
            rst      = ($urandom_range(0, 199) == 0);
            regWrite = 1'($urandom);
            wrAddr   = 3'($urandom);
            wrData   = 8'($urandom);
            ldWnd    = ($urandom_range(0, 2) == 0);
            wndCtrl  = 2'($urandom);
            rdAddr1  = 3'($urandom);
            rdAddr2  = 3'($urandom);
            tick();
        end
        rst = 1'b0; regWrite = 1'b0; ldWnd = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
